// File: rtl/core_req_issuer_pkg.sv
// Shared defaults, FSM state encoding and helpers for the core request issuer.
// Optional feature macro: CORE_REQ_BACKOFF_EN (exponential backoff after retries).
package core_req_issuer_pkg;

    localparam int unsigned N_CORES    = 2;
    localparam int unsigned CORE_REQ_W = 8;
    // Width of the saturating consecutive-retry counter (k).
    localparam int unsigned K_LOG2     = 3;

`ifdef CORE_REQ_BACKOFF_EN
    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_ISSUE   = 2'd1,
        CH_BACKOFF = 2'd2,
        CH_DONE    = 2'd3
    } ch_state_e;
`else
    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_ISSUE = 2'd1,
        CH_DONE  = 2'd3
    } ch_state_e;
`endif

    // Backoff exponent for the k-th consecutive retry (k >= 1), capped.
    function automatic int unsigned bo_exp(input int unsigned k, input int unsigned cap);
        return (k - 1 > cap) ? cap : k - 1;
    endfunction

endpackage

// File: rtl/core_req_issuer_fifo.sv
// Per-channel request queue (module core_req_fifo): power-of-2 depth circular buffer
// with wrapping pointers and an occupancy counter one bit wider than the pointers.
module core_req_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    // Occupancy never exceeds DEPTH, so the MSB alone marks full.
    assign full_o  = cnt_q[AW];
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/core_req_issuer.sv
// Multi-channel core request issuer: per-channel queue plus IDLE/ISSUE/(BACKOFF)/DONE FSM.
// Define CORE_REQ_BACKOFF_EN to enable exponential backoff after retries.
module core_req_issuer
    import core_req_issuer_pkg::*;
#(
    parameter int unsigned N_CH        = N_CORES,
    parameter int unsigned REQ_W       = CORE_REQ_W,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned BO_MAX_LOG2 = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ld_vld,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ld_ch,
    input  logic [REQ_W-1:0]                       ld_data,
    output logic                                   ld_rdy,
    input  logic                                   start,
    output logic [N_CH*REQ_W-1:0]                  core_req_flat,
    output logic [N_CH-1:0]                        core_req_vld,
    input  logic [N_CH-1:0]                        core_req_retry,
    output logic                                   done,
    output logic [N_CH*16-1:0]                     retry_cnt_flat
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
`ifdef CORE_REQ_BACKOFF_EN
    localparam int unsigned BO_W = BO_MAX_LOG2 + 1;
`endif

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("core_req_issuer: DEPTH must be a power of 2 and at least 2");
    end
    if (BO_MAX_LOG2 > 30) begin : g_bad_bo
        $error("core_req_issuer: BO_MAX_LOG2 too large");
    end

    logic [N_CH-1:0] full_w, done_w;

    always_comb begin
        ld_rdy = 1'b0;
        if (32'(ld_ch) < N_CH) begin
            ld_rdy = !full_w[ld_ch] && !done_w[ld_ch];
        end
    end

    assign done = &done_w;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        ch_state_e        state_q;
        logic [15:0]      rcnt_q;
        logic [REQ_W-1:0] head;
        logic             empty, full, loading, push, vld, pop, retry;

        assign loading = ld_vld && (ld_ch == CH_W'(c));
        assign push    = loading && ld_rdy;
        assign retry   = core_req_retry[c];
        assign vld     = (state_q == CH_ISSUE) && !empty;
        assign pop     = vld && !retry;

        core_req_fifo #(
            .W     (REQ_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push),
            .data_i  (ld_data),
            .pop_i   (pop),
            .head_o  (head),
            .empty_o (empty),
            .full_o  (full)
        );

`ifdef CORE_REQ_BACKOFF_EN
        logic [K_LOG2-1:0] cons_q, cons_d;
        logic [BO_W-1:0]   bo_q, bo_d;

        // bo_d is the one-hot backoff length 2^min(k-1, BO_MAX_LOG2).
        always_comb begin
            cons_d = (cons_q == '1) ? cons_q : cons_q + 1'b1;
            bo_d   = '0;
            bo_d[bo_exp(32'(cons_d), BO_MAX_LOG2)] = 1'b1;
        end
`endif

        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q <= CH_IDLE;
                rcnt_q  <= '0;
`ifdef CORE_REQ_BACKOFF_EN
                cons_q  <= '0;
                bo_q    <= '0;
`endif
            end else begin
                if (vld && retry && rcnt_q != 16'hFFFF) begin
                    rcnt_q <= rcnt_q + 16'd1;
                end
                case (state_q)
                    CH_IDLE: begin
                        if (start) begin
                            state_q <= CH_ISSUE;
                        end
                    end
                    CH_ISSUE: begin
                        if (empty && !loading) begin
                            state_q <= CH_DONE;
                        end
`ifdef CORE_REQ_BACKOFF_EN
                        else if (vld && retry) begin
                            state_q <= CH_BACKOFF;
                            cons_q  <= cons_d;
                            bo_q    <= bo_d;
                        end else if (pop) begin
                            cons_q  <= '0;
                        end
`endif
                    end
`ifdef CORE_REQ_BACKOFF_EN
                    CH_BACKOFF: begin
                        bo_q <= bo_q - 1'b1;
                        if (bo_q == BO_W'(1)) begin
                            state_q <= CH_ISSUE;
                        end
                    end
`endif
                    CH_DONE: state_q <= CH_DONE;
                    default: state_q <= CH_IDLE;
                endcase
            end
        end

        assign core_req_vld[c]                   = vld;
        assign core_req_flat[c*REQ_W +: REQ_W]   = vld ? head : '0;
        assign retry_cnt_flat[c*16 +: 16]        = rcnt_q;
        assign full_w[c]                         = full;
        assign done_w[c]                         = (state_q == CH_DONE);
    end

endmodule
